// File: rtl/seq_multiplier.sv
// rtl/seq_multiplier.sv - iterative shift-and-add WIDTH x WIDTH multiplier with start/done handshake
// Optional signed two's-complement mode enabled by defining SEQ_MULT_SIGNED_EN.
module seq_multiplier #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
`ifdef SEQ_MULT_SIGNED_EN
    input  logic                 signed_mode,
`endif
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = ($clog2(WIDTH) < 1) ? 1 : $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state;
    logic [PW-1:0]    mcand;
    logic [PW-1:0]    acc;
    logic [PW-1:0]    acc_next;
    logic [PW-1:0]    mcand_init;
    logic [WIDTH-1:0] mplier;
    logic [CW-1:0]    count;
    logic             last_step;

    assign last_step = (count == LAST_COUNT);

`ifdef SEQ_MULT_SIGNED_EN
    logic sgn;

    assign mcand_init = signed_mode ? {{WIDTH{A[WIDTH-1]}}, A} : {{WIDTH{1'b0}}, A};

    // On the final step mplier[0] is the captured B sign bit, whose weight is negative.
    always_comb begin
        acc_next = acc;
        if (mplier[0]) begin
            if (sgn && last_step) begin
                acc_next = acc - mcand;
            end else begin
                acc_next = acc + mcand;
            end
        end
    end
`else
    assign mcand_init = {{WIDTH{1'b0}}, A};

    always_comb begin
        acc_next = acc;
        if (mplier[0]) begin
            acc_next = acc + mcand;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            mcand   <= '0;
            mplier  <= '0;
            acc     <= '0;
            count   <= '0;
            product <= '0;
`ifdef SEQ_MULT_SIGNED_EN
            sgn     <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        mcand  <= mcand_init;
                        mplier <= B;
                        acc    <= '0;
                        count  <= '0;
`ifdef SEQ_MULT_SIGNED_EN
                        sgn    <= signed_mode;
`endif
                        state  <= S_RUN;
                    end
                end
                S_RUN: begin
                    acc    <= acc_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    count  <= count + CW'(1);
                    if (last_step) begin
                        product <= acc_next;
                        state   <= S_DONE;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy = (state != S_IDLE);
    assign done = (state == S_DONE);

endmodule

// File: tb/tb_seq_multiplier.sv
// tb/tb_seq_multiplier.sv - directed self-checking bench for seq_multiplier (WIDTH=8)
module tb_seq_multiplier;

    localparam int W = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [W-1:0]    a_in;
    logic [W-1:0]    b_in;
    logic            busy;
    logic            done;
    logic [2*W-1:0]  product;
`ifdef SEQ_MULT_SIGNED_EN
    logic            signed_mode = 1'b0;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    seq_multiplier #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .A          (a_in),
        .B          (b_in),
`ifdef SEQ_MULT_SIGNED_EN
        .signed_mode(signed_mode),
`endif
        .busy       (busy),
        .done       (done),
        .product    (product)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issues one op and checks latency (start edge counted as edge 1), result, one-cycle done and hold.
    task automatic do_mult(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [2*W-1:0] exp);
        int edges;
        a_in  = a;
        b_in  = b;
        start = 1'b1;
        tick();
        start = 1'b0;
        edges = 1;
        chk({tag, "_busy_run"}, 32'(busy), 32'd1);
        while (!done && edges < 30) begin
            tick();
            edges++;
        end
        chk({tag, "_latency"}, 32'(edges), 32'd9);
        chk({tag, "_product"}, 32'(product), 32'(exp));
        chk({tag, "_busy_done"}, 32'(busy), 32'd1);
        tick();
        chk({tag, "_done_one_cycle"}, 32'(done), 32'd0);
        chk({tag, "_product_hold"}, 32'(product), 32'(exp));
    endtask

    initial begin
        int edges;
        int pulses;
        rst   = 1'b1;
        start = 1'b0;
        a_in  = '0;
        b_in  = '0;

        // Reset then idle
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("reset_busy", 32'(busy), 32'd0);
            chk("reset_done", 32'(done), 32'd0);
            chk("reset_product", 32'(product), 32'h0000);
        end
        rst = 1'b0;
        tick();
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_product", 32'(product), 32'h0000);

        do_mult("max", 8'hFF, 8'hFF, 16'hFE01);

        // Zero, then identity issued back-to-back with start raised during done
        a_in  = 8'h00;
        b_in  = 8'hA5;
        start = 1'b1;
        tick();
        start = 1'b0;
        edges = 1;
        while (!done && edges < 30) begin
            tick();
            edges++;
        end
        chk("zero_latency", 32'(edges), 32'd9);
        chk("zero_product", 32'(product), 32'h0000);
        a_in  = 8'h01;
        b_in  = 8'hA5;
        start = 1'b1;
        tick();
        edges = 1;
        chk("b2b_idle_gap_busy", 32'(busy), 32'd0);
        tick();
        edges++;
        start = 1'b0;
        chk("b2b_accept_busy", 32'(busy), 32'd1);
        while (!done && edges < 30) begin
            tick();
            edges++;
        end
        chk("b2b_done_spacing", 32'(edges), 32'd10);
        chk("b2b_product", 32'(product), 32'h00A5);
        tick();

        // Start and operand changes while busy must be ignored
        a_in  = 8'h0C;
        b_in  = 8'h0D;
        start = 1'b1;
        tick();
        start  = 1'b0;
        edges  = 1;
        pulses = 0;
        tick();
        edges++;
        a_in  = 8'hFF;
        b_in  = 8'hFF;
        start = 1'b1;
        tick();
        edges++;
        start = 1'b0;
        a_in  = 8'h33;
        b_in  = 8'h77;
        for (int i = 0; i < 25; i++) begin
            if (done) begin
                pulses++;
                if (pulses == 1) begin
                    chk("busyprot_latency", 32'(edges), 32'd9);
                    chk("busyprot_product", 32'(product), 32'h009C);
                end
            end
            tick();
            edges++;
        end
        chk("busyprot_single_done", 32'(pulses), 32'd1);
        chk("busyprot_product_hold", 32'(product), 32'h009C);

        // Reset mid-operation
        a_in  = 8'h10;
        b_in  = 8'h10;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_product", 32'(product), 32'h0000);
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            if (done) pulses++;
            tick();
        end
        chk("midrst_no_done", 32'(pulses), 32'd0);
        do_mult("after_rst", 8'h10, 8'h10, 16'h0100);
        do_mult("mixed", 8'hB7, 8'h3E, 16'h2C52);

`ifdef SEQ_MULT_SIGNED_EN
        signed_mode = 1'b1;
        do_mult("signed_neg3x5", 8'hFD, 8'h05, 16'hFFF1);
        do_mult("signed_min_sq", 8'h80, 8'h80, 16'h4000);
        signed_mode = 1'b0;
        do_mult("unsigned_fdx5", 8'hFD, 8'h05, 16'h04F1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
